// File: rtl/triangle_dispatcher.sv
// Holds a small triangle list and replays it to rasterizer_unit one triangle at a time,
// skipping degenerate triangles. Vertex outputs are packed {x, y, z}, x in the top word.
module triangle_dispatcher #(
  parameter int unsigned MAX_TRIS = 16,
  parameter int unsigned IDX_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_we,
  input  logic [IDX_W-1:0] load_tri,
  input  logic [3:0]       load_word,
  input  logic [31:0]      load_data,
  input  logic [IDX_W:0]   tri_count,
  input  logic             go,
  output logic             busy,
  output logic             frame_done,
  output logic [IDX_W:0]   culled_count,
  output logic             ru_start,
  input  logic             ru_done,
  output logic [95:0]      p1,
  output logic [95:0]      p2,
  output logic [95:0]      p3
);

  localparam int unsigned WORDS = 9;
  localparam int unsigned CNT_W = IDX_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_NEXT, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] culled_q, culled_d;
  logic [95:0]      p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
  logic             busy_q, busy_d;
  logic             start_q, start_d;
  logic             fdone_q, fdone_d;

  logic [31:0]      mem_q [MAX_TRIS][WORDS];
  logic [31:0]      w_c [WORDS];
  logic             wr_en_c;
  logic             degen_c;
  logic [CNT_W-1:0] go_count_c;

  // Triangle list: no reset, so contents survive a reset pulse.
  assign wr_en_c = load_we && !busy_q && (32'(load_tri) < MAX_TRIS)
                   && (load_word < 4'(WORDS));

  always_ff @(posedge clk) begin
    if (wr_en_c) mem_q[load_tri][load_word] <= load_data;
  end

  always_comb begin
    for (int k = 0; k < WORDS; k++) w_c[k] = mem_q[idx_q][k];
  end

  // Degenerate when any two vertices coincide bit-exactly in x and y; z is ignored.
  assign degen_c = ((w_c[0] == w_c[3]) && (w_c[1] == w_c[4]))
                || ((w_c[0] == w_c[6]) && (w_c[1] == w_c[7]))
                || ((w_c[3] == w_c[6]) && (w_c[4] == w_c[7]));

  assign go_count_c = (tri_count > CNT_W'(MAX_TRIS)) ? CNT_W'(MAX_TRIS) : tri_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      count_q  <= '0;
      culled_q <= '0;
      p1_q     <= '0;
      p2_q     <= '0;
      p3_q     <= '0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      fdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      count_q  <= count_d;
      culled_q <= culled_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      p3_q     <= p3_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
      fdone_q  <= fdone_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    count_d  = count_q;
    culled_d = culled_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    p3_d     = p3_q;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          count_d  = go_count_c;
          idx_d    = '0;
          culled_d = '0;
          state_d  = (go_count_c == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        p1_d = {w_c[0], w_c[1], w_c[2]};
        p2_d = {w_c[3], w_c[4], w_c[5]};
        p3_d = {w_c[6], w_c[7], w_c[8]};
        if (degen_c) begin
          culled_d = culled_q + CNT_W'(1);
          state_d  = S_NEXT;
        end else begin
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: if (!ru_done) state_d = S_WAIT;
      S_WAIT:  if (ru_done) state_d = S_NEXT;
      S_NEXT: begin
        if (CNT_W'(idx_q) + CNT_W'(1) == count_q) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they track the state register.
  always_comb begin
    busy_d  = (state_d != S_IDLE);
    start_d = (state_d == S_ISSUE);
    fdone_d = (state_d == S_DONE);
  end

  assign busy         = busy_q;
  assign frame_done   = fdone_q;
  assign culled_count = culled_q;
  assign ru_start     = start_q;
  assign p1           = p1_q;
  assign p2           = p2_q;
  assign p3           = p3_q;

endmodule

// File: tb/tb_triangle_dispatcher.sv
// Directed bench for triangle_dispatcher: a list-level model predicts which slots get
// handshaken and how many are culled; a monitor checks the DUT against it every cycle.
module tb_triangle_dispatcher;

  localparam int unsigned MAX_TRIS = 16;
  localparam int unsigned IDX_W    = 4;

  localparam logic [95:0]  T1_P1 = {32'h428a0000, 32'h428a0000, 32'h3f800000};
  localparam logic [95:0]  T1_P2 = {32'h428a0000, 32'h43290000, 32'h3f800000};
  localparam logic [95:0]  T1_P3 = {32'h43290000, 32'h428a0000, 32'h3f800000};
  localparam logic [287:0] T1    = {T1_P1, T1_P2, T1_P3};
  localparam logic [287:0] TDEG  = {32'h40000000, 32'h40400000, 32'h00000000,
                                    32'h40000000, 32'h40400000, 32'h3f800000,
                                    32'h40800000, 32'h40a00000, 32'h00000000};
  localparam logic [287:0] T2    = {32'h41000000, 32'h41100000, 32'h00000000,
                                    32'h41200000, 32'h41100000, 32'h00000000,
                                    32'h41000000, 32'h41300000, 32'h00000000};

  logic             clk = 1'b0;
  logic             reset;
  logic             load_we;
  logic [IDX_W-1:0] load_tri;
  logic [3:0]       load_word;
  logic [31:0]      load_data;
  logic [IDX_W:0]   tri_count;
  logic             go;
  logic             busy;
  logic             frame_done;
  logic [IDX_W:0]   culled_count;
  logic             ru_start;
  logic             ru_done;
  logic [95:0]      p1, p2, p3;

  triangle_dispatcher #(.MAX_TRIS(MAX_TRIS), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .load_we(load_we), .load_tri(load_tri),
    .load_word(load_word), .load_data(load_data), .tri_count(tri_count), .go(go),
    .busy(busy), .frame_done(frame_done), .culled_count(culled_count),
    .ru_start(ru_start), .ru_done(ru_done), .p1(p1), .p2(p2), .p3(p3)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] shadow [MAX_TRIS][9];
  int          exp_q[$];
  int          exp_culled = 0;
  int          exp_last   = -1;
  int          n_starts   = 0;
  int          n_frames   = 0;
  int          cur_slot   = 0;
  bit          cur_valid  = 1'b0;
  bit          rast_auto  = 1'b1;
  logic        prev_start = 1'b0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [95:0] vtx(input int s, input int v);
    return {shadow[s][3*v], shadow[s][3*v+1], shadow[s][3*v+2]};
  endfunction

  function automatic bit is_degen(input int s);
    bit d = 1'b0;
    for (int a = 0; a < 3; a++)
      for (int b = a + 1; b < 3; b++)
        if (shadow[s][3*a] == shadow[s][3*b] && shadow[s][3*a+1] == shadow[s][3*b+1]) d = 1'b1;
    return d;
  endfunction

  // Expected outcome of a whole pass from the current list contents.
  task automatic model_pass(input int cnt);
    int c;
    c = (cnt > int'(MAX_TRIS)) ? int'(MAX_TRIS) : cnt;
    exp_q.delete();
    exp_culled = 0;
    exp_last   = c - 1;
    for (int s = 0; s < c; s++) begin
      if (is_degen(s)) exp_culled++;
      else exp_q.push_back(s);
    end
  endtask

  task automatic model_abort();
    exp_q.delete();
    cur_valid = 1'b0;
  endtask

  task automatic load(input int slot, input int word, input logic [31:0] data, input bit accept);
    @(negedge clk);
    load_we   = 1'b1;
    load_tri  = IDX_W'(slot);
    load_word = 4'(word);
    load_data = data;
    @(negedge clk);
    load_we = 1'b0;
    if (accept) shadow[slot][word] = data;
  endtask

  task automatic load_tri9(input int slot, input logic [287:0] w);
    for (int k = 0; k < 9; k++) load(slot, k, w[287-32*k -: 32], 1'b1);
  endtask

  // Returns at the negedge of the first cycle after go is sampled.
  task automatic pulse_go(input int cnt);
    @(negedge clk);
    model_pass(cnt);
    go        = 1'b1;
    tri_count = (IDX_W+1)'(cnt);
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_frame(input int start, input int max_cyc, output int lat);
    lat = start;
    while (!frame_done && lat < max_cyc) begin
      @(negedge clk);
      lat++;
    end
    chkb("frame_seen", frame_done, 1'b1);
  endtask

  // Rasterizer model: drops done one cycle after start, raises it 50 cycles later.
  initial begin : rasterizer
    ru_done = 1'b1;
    forever begin
      @(posedge clk);
      if (rast_auto && ru_start === 1'b1) begin
        #1 ru_done = 1'b0;
        repeat (50) @(posedge clk);
        #1 ru_done = 1'b1;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (ru_start && !prev_start) begin
        n_starts++;
        chkb("start_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          cur_slot  = exp_q.pop_front();
          cur_valid = 1'b1;
        end else begin
          cur_valid = 1'b0;
        end
      end
      if (ru_start && cur_valid) begin
        chk("p1_during_start", p1, vtx(cur_slot, 0));
        chk("p2_during_start", p2, vtx(cur_slot, 1));
        chk("p3_during_start", p3, vtx(cur_slot, 2));
      end
      if (frame_done) begin
        n_frames++;
        chki("frame_pending_slots", exp_q.size(), 0);
        chki("frame_culled", int'(culled_count), exp_culled);
        if (exp_last >= 0) chk("p3_at_frame", p3, vtx(exp_last, 2));
        cur_valid = 1'b0;
      end
      prev_start = ru_start;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int lat, f0, s0;
    reset = 1'b1; load_we = 1'b0; load_tri = '0; load_word = '0; load_data = '0;
    tri_count = '0; go = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_ru_start", ru_start, 1'b0);
    chkb("rst_frame_done", frame_done, 1'b0);
    chki("rst_culled", int'(culled_count), 0);
    chk("rst_p1", p1, '0);

    // Single triangle
    load_tri9(0, T1);
    f0 = n_frames; s0 = n_starts;
    pulse_go(1);
    chkb("t1_busy_n1", busy, 1'b1);
    chkb("t1_start_n1", ru_start, 1'b0);
    @(negedge clk);
    chkb("t1_start_n2", ru_start, 1'b1);
    chk("t1_p1", p1, T1_P1);
    chk("t1_p2", p2, T1_P2);
    chk("t1_p3", p3, T1_P3);
    wait_frame(2, 300, lat);
    chki("t1_frame_latency", lat, 55);
    chkb("t1_busy_at_frame", busy, 1'b1);
    @(negedge clk);
    chkb("t1_busy_after_frame", busy, 1'b0);
    repeat (3) @(negedge clk);
    chki("t1_frames", n_frames - f0, 1);
    chki("t1_starts", n_starts - s0, 1);
    chki("t1_culled", int'(culled_count), 0);
    chk("t1_p2_hold", p2, T1_P2);

    // Three triangles, middle degenerate
    load_tri9(1, TDEG);
    load_tri9(2, T2);
    f0 = n_frames; s0 = n_starts;
    pulse_go(3);
    wait_frame(1, 500, lat);
    repeat (3) @(negedge clk);
    chki("t2_starts", n_starts - s0, 2);
    chki("t2_frames", n_frames - f0, 1);
    chki("t2_culled", int'(culled_count), 1);

    // Zero count
    f0 = n_frames; s0 = n_starts;
    pulse_go(0);
    chkb("t3_frame_n1", frame_done, 1'b1);
    chkb("t3_busy_n1", busy, 1'b1);
    @(negedge clk);
    chkb("t3_frame_n2", frame_done, 1'b0);
    chkb("t3_busy_n2", busy, 1'b0);
    repeat (2) @(negedge clk);
    chki("t3_starts", n_starts - s0, 0);
    chki("t3_frames", n_frames - f0, 1);

    // Count above capacity clamps to 16
    for (int s = 0; s < int'(MAX_TRIS); s++)
      load_tri9(s, {32'(32'h100 + s), 32'h200, 32'h0,
                    32'(32'h100 + s), 32'h300, 32'h0,
                    32'(32'h400 + s), 32'h200, 32'h0});
    f0 = n_frames; s0 = n_starts;
    pulse_go(20);
    wait_frame(1, 3000, lat);
    repeat (3) @(negedge clk);
    chki("t3b_starts", n_starts - s0, 16);
    chki("t3b_frames", n_frames - f0, 1);
    chki("t3b_culled", int'(culled_count), 0);

    // Busy guards: go and load during WAIT are dropped
    load_tri9(0, T1);
    f0 = n_frames; s0 = n_starts;
    pulse_go(1);
    lat = 0;
    while (!(n_starts > s0 && !ru_start) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chkb("t4_in_wait", busy && !ru_start && n_starts > s0, 1'b1);
    @(negedge clk);
    go = 1'b1; tri_count = 5'd3;
    load_we = 1'b1; load_tri = '0; load_word = 4'd0; load_data = 32'hdeadbeef;
    @(negedge clk);
    go = 1'b0; load_we = 1'b0;
    wait_frame(1, 300, lat);
    repeat (5) @(negedge clk);
    chki("t4_frames", n_frames - f0, 1);
    chki("t4_starts", n_starts - s0, 1);
    chkb("t4_idle", busy, 1'b0);
    pulse_go(1);
    wait_frame(1, 300, lat);
    chk("t4_p1_preserved", p1, T1_P1);
    repeat (3) @(negedge clk);

    // Reset mid-handshake, then replay from the preserved list
    rast_auto = 1'b0;
    ru_done   = 1'b1;
    pulse_go(1);
    @(negedge clk);
    chkb("t5_start_before_reset", ru_start, 1'b1);
    reset = 1'b1;
    model_abort();
    @(negedge clk);
    chkb("t5_rst_start", ru_start, 1'b0);
    chkb("t5_rst_busy", busy, 1'b0);
    chkb("t5_rst_frame", frame_done, 1'b0);
    chk("t5_rst_p1", p1, '0);
    chk("t5_rst_p2", p2, '0);
    chk("t5_rst_p3", p3, '0);
    reset = 1'b0;
    rast_auto = 1'b1;
    f0 = n_frames; s0 = n_starts;
    pulse_go(1);
    wait_frame(1, 300, lat);
    chk("t5_replay_p1", p1, T1_P1);
    chk("t5_replay_p3", p3, T1_P3);
    repeat (3) @(negedge clk);
    chki("t5_starts", n_starts - s0, 1);

    // ru_done already low at ISSUE
    rast_auto = 1'b0;
    ru_done   = 1'b0;
    s0 = n_starts;
    pulse_go(1);
    chkb("t6_start_n1", ru_start, 1'b0);
    @(negedge clk);
    chkb("t6_start_n2", ru_start, 1'b1);
    @(negedge clk);
    chkb("t6_start_n3", ru_start, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chkb("t6_wait_busy", busy, 1'b1);
      chkb("t6_wait_noframe", frame_done, 1'b0);
    end
    ru_done = 1'b1;
    @(negedge clk);
    chkb("t6_next_noframe", frame_done, 1'b0);
    @(negedge clk);
    chkb("t6_frame", frame_done, 1'b1);
    rast_auto = 1'b1;
    repeat (3) @(negedge clk);
    chki("t6_starts", n_starts - s0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
